// File: rtl/fir_mul_pkg.sv
`default_nettype none
// ============================================================================
// Module : fir_mul_pkg
// Brief  : Shared helpers for the folded-FIR multiplier pipe.
//          - clog2_min1(): channel-tag width, never below one bit
//          - default configuration values and the derived P_W/CH_W
//          - stage_def_t: pipe stage record {v, ch, data} for the default
//            configuration
// Rev    : 1.0  initial release
// ============================================================================
package fir_mul_pkg;

   // ceil(log2(n)), clamped to at least 1 so a single-channel build still
   // carries a real tag bit
   function automatic int clog2_min1(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) begin
         r = r + 1;
      end
      if (r < 1) begin
         r = 1;
      end
      return r;
   endfunction

   localparam int A_W_DEF       = 19;
   localparam int B_W_DEF       = 8;
   localparam int OUT_W_DEF     = 27;
   localparam int SHIFT_DEF     = 0;
   localparam int NUM_STAGE_DEF = 3;
   localparam int NUM_CH_DEF    = 4;

   // signed x zero-extended-unsigned product always fits A_W+B_W bits
   localparam int P_W_DEF  = A_W_DEF + B_W_DEF;
   localparam int CH_W_DEF = clog2_min1(NUM_CH_DEF);

   typedef struct packed {
      logic                v;
      logic [CH_W_DEF-1:0] ch;
      logic [P_W_DEF-1:0]  data;
   } stage_def_t;

endpackage
`default_nettype wire

// File: rtl/fir_mul_round_sat.sv
`default_nettype none
// ============================================================================
// Module : fir_mul_round_sat
// Brief  : Combinational post-processing of a P_W-bit signed product:
//          arithmetic right shift by SHIFT, range check against OUT_W,
//          and narrowing to OUT_W.
//          Build option FIR_MUL_ROUND_SAT_EN:
//            defined   - round half up before the shift (SHIFT>0) and
//                        saturate out-of-range results to max/min
//            undefined - truncating shift, out-of-range results wrap
//          o_ovf flags an out-of-range result in both builds.
// Ports  : i_prod  in   P_W    signed product
//          o_data  out  OUT_W  signed result
//          o_ovf   out  1      shifted result did not fit OUT_W
// Rev    : 1.0  initial release
// ============================================================================
module fir_mul_round_sat
   import fir_mul_pkg::*;
#(
   parameter int P_W   = P_W_DEF,
   parameter int OUT_W = OUT_W_DEF,
   parameter int SHIFT = SHIFT_DEF
) (
   input  logic signed [P_W-1:0]   i_prod,
   output logic signed [OUT_W-1:0] o_data,
   output logic                    o_ovf
);

   // one guard bit so the rounding add can never wrap
   localparam int R_W = P_W + 1;

   logic signed [R_W-1:0] w_ext;
   logic signed [R_W-1:0] w_r;

   assign w_ext = {i_prod[P_W-1], i_prod};

`ifdef FIR_MUL_ROUND_SAT_EN
   generate
      if (SHIFT > 0) begin : g_round
         localparam logic signed [R_W-1:0] c_half = R_W'(1) << (SHIFT - 1);
         logic signed [R_W-1:0] w_sum;
         assign w_sum = w_ext + c_half;
         assign w_r   = w_sum >>> SHIFT;
      end else begin : g_noround
         assign w_r = w_ext;
      end
   endgenerate
`else
   assign w_r = w_ext >>> SHIFT;
`endif

   generate
      if (OUT_W >= R_W) begin : g_wide
         // every representable result fits; plain sign extension
         assign o_data = OUT_W'(w_r);
         assign o_ovf  = 1'b0;
      end else begin : g_narrow
         // fits iff all bits from the OUT_W sign bit upward agree
         logic [R_W-OUT_W:0] w_top;
         logic               w_fits;
         assign w_top  = w_r[R_W-1:OUT_W-1];
         assign w_fits = (&w_top) | (~|w_top);
         assign o_ovf  = ~w_fits;
`ifdef FIR_MUL_ROUND_SAT_EN
         localparam logic signed [OUT_W-1:0] c_max = {1'b0, {(OUT_W-1){1'b1}}};
         localparam logic signed [OUT_W-1:0] c_min = {1'b1, {(OUT_W-1){1'b0}}};
         assign o_data = w_fits        ? w_r[OUT_W-1:0] :
                         w_r[R_W-1]    ? c_min          : c_max;
`else
         assign o_data = w_r[OUT_W-1:0];
`endif
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/fir_mul_pipe.sv
`default_nettype none
// ============================================================================
// Module : fir_mul_pipe
// Brief  : Pipelined signed x unsigned multiplier for the folded FIR
//          datapath. Latency NUM_STAGE cycles, one beat per cycle, channel
//          tag carried alongside, valid/ready backpressure with a
//          combinational ready chain (no bubbles), per-channel sticky
//          overflow flags.
//          Build option FIR_MUL_ROUND_SAT_EN selects round/saturate instead
//          of truncate/wrap (see fir_mul_round_sat).
// Ports  : ap_clk      in   1       clock, rising edge
//          ap_rst_n    in   1       async active-low reset
//          in_valid    in   1       input beat valid
//          in_ready    out  1       beat accepted when in_valid & in_ready
//          in_a        in   A_W     signed sample
//          in_b        in   B_W     unsigned coefficient
//          in_ch       in   CH_W    channel tag
//          out_valid   out  1       output beat valid
//          out_ready   in   1       downstream accept
//          out_data    out  OUT_W   signed result
//          out_ch      out  CH_W    tag of out_data
//          out_ovf     out  1       result did not fit OUT_W
//          ovf_sticky  out  NUM_CH  per-channel sticky overflow
//          ovf_clr     in   NUM_CH  per-channel clear pulse
// Rev    : 1.0  initial release
// ============================================================================
module fir_mul_pipe
   import fir_mul_pkg::*;
#(
   parameter int A_W       = A_W_DEF,
   parameter int B_W       = B_W_DEF,
   parameter int OUT_W     = OUT_W_DEF,
   parameter int SHIFT     = SHIFT_DEF,
   parameter int NUM_STAGE = NUM_STAGE_DEF,
   parameter int NUM_CH    = NUM_CH_DEF
) (
   input  logic                              ap_clk,
   input  logic                              ap_rst_n,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic signed [A_W-1:0]             in_a,
   input  logic        [B_W-1:0]             in_b,
   input  logic [clog2_min1(NUM_CH)-1:0]     in_ch,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic signed [OUT_W-1:0]           out_data,
   output logic [clog2_min1(NUM_CH)-1:0]     out_ch,
   output logic                              out_ovf,
   output logic [NUM_CH-1:0]                 ovf_sticky,
   input  logic [NUM_CH-1:0]                 ovf_clr
);

   localparam int P_W  = A_W + B_W;
   localparam int CH_W = clog2_min1(NUM_CH);

   // Stage record for stages 1..NUM_STAGE-1. Stage 1 packs {a, b} into
   // data (exactly P_W bits); later stages hold the full product.
   typedef struct packed {
      logic            v;
      logic [CH_W-1:0] ch;
      logic [P_W-1:0]  data;
   } pipe_stage_t;

   pipe_stage_t              r_stg [1:NUM_STAGE-1];
   logic                     r_out_valid;
   logic signed [OUT_W-1:0]  r_out_data;
   logic [CH_W-1:0]          r_out_ch;
   logic                     r_out_ovf;
   logic [NUM_CH-1:0]        r_sticky;

   logic [NUM_STAGE:1]       w_adv;
   logic                     w_acc;
   logic signed [P_W-1:0]    w_a_ext;
   logic signed [P_W-1:0]    w_b_ext;
   logic signed [P_W-1:0]    w_prod;
   logic signed [P_W-1:0]    w_fin;
   logic signed [OUT_W-1:0]  w_res;
   logic                     w_ovf;
   logic [NUM_CH-1:0]        w_set;

   // ------------------------------------------------------------------
   // Ready chain: stage k may load when it is empty or every stage
   // downstream of it moves. Unrolled as a running OR from the output
   // back toward the input so the chain has no combinational self-loop.
   // ------------------------------------------------------------------
   always_comb begin
      w_acc            = out_ready | ~r_out_valid;
      w_adv[NUM_STAGE] = w_acc;
      for (int k = NUM_STAGE - 1; k >= 1; k--) begin
         w_acc    = w_acc | ~r_stg[k].v;
         w_adv[k] = w_acc;
      end
   end

   assign in_ready = w_adv[1];

   // ------------------------------------------------------------------
   // Multiply. Sign-extend a, zero-extend b, multiply modulo 2^P_W: the
   // true product always fits P_W bits, so no upper bits are lost.
   // ------------------------------------------------------------------
   assign w_a_ext = {{B_W{r_stg[1].data[P_W-1]}}, r_stg[1].data[P_W-1:B_W]};
   assign w_b_ext = {{A_W{1'b0}}, r_stg[1].data[B_W-1:0]};
   assign w_prod  = w_a_ext * w_b_ext;

   // Product feeding the final stage: straight from the multiplier in a
   // two-stage pipe, otherwise from the last delay stage.
   generate
      if (NUM_STAGE == 2) begin : g_short
         assign w_fin = w_prod;
      end else begin : g_long
         assign w_fin = r_stg[NUM_STAGE-1].data;
      end
   endgenerate

   fir_mul_round_sat #(
      .P_W   (P_W),
      .OUT_W (OUT_W),
      .SHIFT (SHIFT)
   ) u_round_sat (
      .i_prod (w_fin),
      .o_data (w_res),
      .o_ovf  (w_ovf)
   );

   // ------------------------------------------------------------------
   // Pipe registers. Payload only loads with a valid beat so that a
   // bubble never disturbs the held output data.
   // ------------------------------------------------------------------
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         for (int k = 1; k < NUM_STAGE; k++) begin
            r_stg[k] <= '0;
         end
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_ch    <= '0;
         r_out_ovf   <= 1'b0;
      end else begin
         if (w_adv[1]) begin
            r_stg[1].v <= in_valid;
            if (in_valid) begin
               r_stg[1].ch   <= in_ch;
               r_stg[1].data <= {in_a, in_b};
            end
         end
         for (int k = 2; k < NUM_STAGE; k++) begin
            if (w_adv[k]) begin
               r_stg[k].v <= r_stg[k-1].v;
               if (r_stg[k-1].v) begin
                  r_stg[k].ch   <= r_stg[k-1].ch;
                  r_stg[k].data <= (k == 2) ? w_prod : r_stg[k-1].data;
               end
            end
         end
         if (w_adv[NUM_STAGE]) begin
            r_out_valid <= r_stg[NUM_STAGE-1].v;
            if (r_stg[NUM_STAGE-1].v) begin
               r_out_data <= w_res;
               r_out_ovf  <= w_ovf;
               r_out_ch   <= r_stg[NUM_STAGE-1].ch;
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Sticky overflow. Set on consumption of an overflowing beat; tags
   // outside 0..NUM_CH-1 match no bit. Set has priority over clear.
   // ------------------------------------------------------------------
   always_comb begin
      w_set = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (r_out_valid && out_ready && r_out_ovf && (r_out_ch == CH_W'(i))) begin
            w_set[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_sticky <= '0;
      end else begin
         r_sticky <= (r_sticky & ~ovf_clr) | w_set;
      end
   end

   assign out_valid  = r_out_valid;
   assign out_data   = r_out_data;
   assign out_ch     = r_out_ch;
   assign out_ovf    = r_out_ovf;
   assign ovf_sticky = r_sticky;

endmodule
`default_nettype wire
